// File: rtl/dontcare_pipe.sv
// rtl/dontcare_pipe.sv - elastic valid/ready register pipeline with selectable empty-slot data fill
module dontcare_pipe #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 3,
    parameter int FILL_MODE = 0
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] src_valid;
    logic [WIDTH-1:0] src_data [DEPTH];
    logic             adv_run;
    logic [OCC_W-1:0] occ_sum;

    // An empty stage always accepts, so bubbles collapse toward the output.
    always_comb begin
        adv_run = out_ready;
        adv     = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv_run = !valid_q[i] || adv_run;
            adv[i]  = adv_run;
        end
    end

    always_comb begin
        src_valid    = '0;
        src_valid[0] = in_valid;
        src_data[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            src_valid[i] = valid_q[i-1];
            src_data[i]  = data_q[i-1];
        end
    end

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
            if (adv[i]) begin
                valid_d[i] = src_valid[i];
                if (src_valid[i]) begin
                    data_d[i] = src_data[i];
                end else if (FILL_MODE == 1) begin
                    data_d[i] = '0;
                end else if (FILL_MODE != 2) begin
                    data_d[i] = 'x;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    always_comb begin
        occ_sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_sum = occ_sum + OCC_W'(valid_q[i]);
        end
    end

    // The x fill is confined to the data lane; valid, ready and occupancy stay defined.
    always_comb begin
        if (valid_q[DEPTH-1]) begin
            out_data = data_q[DEPTH-1];
        end else if (FILL_MODE == 1) begin
            out_data = '0;
        end else if (FILL_MODE == 2) begin
            out_data = data_q[DEPTH-1];
        end else begin
            out_data = 'x;
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = valid_q[DEPTH-1];
    assign occupancy = occ_sum;

endmodule

// File: tb/tb_dontcare_pipe.sv
// tb/tb_dontcare_pipe.sv - self-checking bench for dontcare_pipe, all three fill modes in lockstep
module tb_dontcare_pipe;

    localparam int W = 8;
    localparam int D = 3;

    logic         clock = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] in_data;
    logic         in_ready  [3];
    logic         out_valid [3];
    logic [W-1:0] out_data  [3];
    logic [1:0]   occupancy [3];
    logic [W-1:0] xv;

    always #5 clock = ~clock;

    dontcare_pipe #(.WIDTH(W), .DEPTH(D), .FILL_MODE(0)) u_dut0 (
        .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_data(in_data), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_data(out_data[0]), .occupancy(occupancy[0]));
    dontcare_pipe #(.WIDTH(W), .DEPTH(D), .FILL_MODE(1)) u_dut1 (
        .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_data(in_data), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_data(out_data[1]), .occupancy(occupancy[1]));
    dontcare_pipe #(.WIDTH(W), .DEPTH(D), .FILL_MODE(2)) u_dut2 (
        .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
        .in_data(in_data), .out_valid(out_valid[2]), .out_ready(out_ready),
        .out_data(out_data[2]), .occupancy(occupancy[2]));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_x(input string name, input logic [W-1:0] act);
        n_checks++;
        if (act !== xv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected all-x", name, act);
        end
    endtask

    // Reference model: FIFO of items, each tagged with its stage position.
    int           m_pos [$];
    logic [W-1:0] m_dat [$];
    logic [W-1:0] m_last;
    int           m_np  [$];
    bit           m_ir;

    function automatic void m_plan(input logic ordy);
        int lim;
        lim  = ordy ? D : D - 1;
        m_np = {};
        foreach (m_pos[k]) begin
            int p;
            p = m_pos[k] + 1;
            if (p > lim) p = lim;
            m_np.push_back(p);
            lim = p - 1;
        end
        m_ir = (lim >= 0);
    endfunction

    function automatic void m_reset();
        m_pos  = {};
        m_dat  = {};
        m_last = '0;
    endfunction

    function automatic void m_advance(input logic iv, input logic [W-1:0] id, input logic ordy);
        int           npos [$];
        logic [W-1:0] ndat [$];
        m_plan(ordy);
        foreach (m_pos[k]) begin
            if (m_np[k] < D) begin
                npos.push_back(m_np[k]);
                ndat.push_back(m_dat[k]);
                if (m_np[k] == D - 1) m_last = m_dat[k];
            end
        end
        if (iv && m_ir) begin
            npos.push_back(0);
            ndat.push_back(id);
            if (D == 1) m_last = id;
        end
        m_pos = npos;
        m_dat = ndat;
    endfunction

    task automatic check_model();
        logic         e_ov;
        logic [W-1:0] e_d;
        m_plan(out_ready);
        e_ov = (m_pos.size() > 0) && (m_pos[0] == D - 1);
        e_d  = e_ov ? m_dat[0] : '0;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("model in_ready[%0d]", j), 32'(in_ready[j]), 32'(m_ir));
            chk($sformatf("model out_valid[%0d]", j), 32'(out_valid[j]), 32'(e_ov));
            chk($sformatf("model occupancy[%0d]", j), 32'(occupancy[j]), 32'(m_pos.size()));
        end
        if (e_ov) chk("model out_data mode0", 32'(out_data[0]), 32'(e_d));
        else      chk_x("model out_data mode0 idle", out_data[0]);
        chk("model out_data mode1", 32'(out_data[1]), 32'(e_d));
        chk("model out_data mode2", 32'(out_data[2]), e_ov ? 32'(e_d) : 32'(m_last));
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] id, input logic ordy);
        @(negedge clock);
        in_valid  = iv;
        out_ready = ordy;
        if (iv)                in_data = id;
        else if ($urandom % 2) in_data = 'x;
        else                   in_data = W'($urandom);
        #1;
    endtask

    task automatic advance();
        @(posedge clock);
        m_advance(in_valid, in_data, out_ready);
    endtask

    task automatic cycle(input logic iv, input logic [W-1:0] id, input logic ordy);
        drive(iv, id, ordy);
        check_model();
        advance();
    endtask

    task automatic check_reset_state(input string tag);
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("%s out_valid[%0d]", tag, j), 32'(out_valid[j]), 32'd0);
            chk($sformatf("%s occupancy[%0d]", tag, j), 32'(occupancy[j]), 32'd0);
            chk($sformatf("%s in_ready[%0d]", tag, j), 32'(in_ready[j]), 32'd1);
        end
        chk_x({tag, " out_data mode0"}, out_data[0]);
        chk({tag, " out_data mode1"}, 32'(out_data[1]), 32'd0);
        chk({tag, " out_data mode2"}, 32'(out_data[2]), 32'd0);
    endtask

    typedef struct {
        logic         iv;
        logic [W-1:0] id;
        logic         ordy;
        logic         ov;
        logic [W-1:0] od;
        logic         ir;
        int           occ;
        logic [W-1:0] od2;
    } vec_t;

    vec_t tbl [24];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        xv = 'x;
        // latency, backpressure, bubble collapse
        tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b1, 0, 8'h00};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1, 8'h00};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1, 8'h00};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b1, 1, 8'hA5};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 0, 8'hA5};
        tbl[5]  = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 0, 8'hA5};
        tbl[6]  = '{1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 1'b1, 1, 8'hA5};
        tbl[7]  = '{1'b1, 8'h03, 1'b0, 1'b0, 8'h00, 1'b1, 2, 8'hA5};
        tbl[8]  = '{1'b1, 8'h04, 1'b0, 1'b1, 8'h01, 1'b0, 3, 8'h01};
        tbl[9]  = '{1'b1, 8'h04, 1'b0, 1'b1, 8'h01, 1'b0, 3, 8'h01};
        tbl[10] = '{1'b1, 8'h04, 1'b1, 1'b1, 8'h01, 1'b1, 3, 8'h01};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b1, 3, 8'h02};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 1'b1, 2, 8'h03};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 1'b1, 1, 8'h04};
        tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 0, 8'h04};
        tbl[15] = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 1'b1, 0, 8'h04};
        tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1, 8'h04};
        tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1, 8'h04};
        tbl[18] = '{1'b1, 8'h20, 1'b0, 1'b1, 8'h10, 1'b1, 1, 8'h10};
        tbl[19] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 1'b1, 2, 8'h10};
        tbl[20] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 1'b1, 2, 8'h10};
        tbl[21] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 1'b1, 2, 8'h10};
        tbl[22] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 1'b1, 1, 8'h20};
        tbl[23] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 0, 8'h20};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        m_reset();
        repeat (2) @(negedge clock);
        #1;
        check_reset_state("reset");
        @(negedge clock);
        rst_n = 1'b1;

        for (int r = 0; r < 24; r++) begin
            drive(tbl[r].iv, tbl[r].id, tbl[r].ordy);
            chk($sformatf("tbl[%0d] out_valid", r), 32'(out_valid[0]), 32'(tbl[r].ov));
            chk($sformatf("tbl[%0d] in_ready", r), 32'(in_ready[0]), 32'(tbl[r].ir));
            chk($sformatf("tbl[%0d] occupancy", r), 32'(occupancy[0]), 32'(tbl[r].occ));
            if (tbl[r].ov) chk($sformatf("tbl[%0d] out_data", r), 32'(out_data[0]), 32'(tbl[r].od));
            else           chk_x($sformatf("tbl[%0d] out_data idle", r), out_data[0]);
            chk($sformatf("tbl[%0d] out_data mode2", r), 32'(out_data[2]), 32'(tbl[r].od2));
            check_model();
            advance();
        end

        // full pipeline streaming at one item per cycle
        for (int k = 0; k < 3; k++) cycle(1'b1, 8'(8'h30 + k), 1'b0);
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 8'(8'h33 + k), 1'b1);
            chk($sformatf("stream[%0d] occupancy", k), 32'(occupancy[0]), 32'd3);
            chk($sformatf("stream[%0d] out_valid", k), 32'(out_valid[0]), 32'd1);
            chk($sformatf("stream[%0d] in_ready", k), 32'(in_ready[0]), 32'd1);
            chk($sformatf("stream[%0d] out_data", k), 32'(out_data[0]), 32'(8'h30 + k));
            check_model();
            advance();
        end
        for (int k = 0; k < 4; k++) cycle(1'b0, 8'h00, 1'b1);

        // asynchronous reset between edges with two items in flight
        cycle(1'b1, 8'h70, 1'b0);
        cycle(1'b1, 8'h71, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        chk("pre-reset occupancy", 32'(occupancy[0]), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("midreset");
        m_reset();
        @(negedge clock);
        rst_n = 1'b1;
        cycle(1'b1, 8'h5A, 1'b1);
        seen = 0;
        for (int k = 1; k <= 8 && seen == 0; k++) begin
            drive(1'b0, 8'h00, 1'b1);
            if (out_valid[0]) begin
                seen = k;
                chk("post-reset out_data", 32'(out_data[0]), 32'h5A);
            end
            check_model();
            advance();
        end
        chk("post-reset latency", 32'(seen), 32'd3);

        // randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic iv, ordy;
            iv   = ($urandom % 4) != 0;
            ordy = (k < 200) ? (($urandom % 3) == 0) : (($urandom % 4) != 0);
            cycle(iv, W'($urandom), ordy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
